seq_counter_ctrl: RTL
=====================

Name: seq_counter_ctrl

Overview:
- Upstream stage of the 7-segment decoder: generates the 4-bit state qd,qc,qb,qa that the decoder turns into segments a..g.
- Button-driven run/pause/clear state machine gating a prescaled modulo-MOD up/down counter, with synchronous load and a terminal-count pulse.
- All sequential logic lives here; the decoder remains purely combinational.

Parameters:
- DIV, 4, prescaler division ratio: the count advances once every DIV clk cycles while running. Legal range is ≥2; the board build uses 50_000_000.
- MOD, 10, counter modulus: the count range is 0..MOD-1. Legal range is 2..16.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start_btn  in  1  asynchronous level from push-button: run/resume
- stop_btn  in  1  asynchronous level from push-button: pause/clear
- dir  in  1  1 = count up, 0 = count down; sampled on each tick
- load  in  1  synchronous load strobe, already synchronous to clk
- load_val  in  4  value to load
- qd  out  1  count bit 3 (MSB)
- qc  out  1  count bit 2
- qb  out  1  count bit 1
- qa  out  1  count bit 0 (LSB)
- tc  out  1  one-cycle pulse on wrap-around
- running  out  1  high while in state RUN

Behaviour:
- Reset: while rst=1, and immediately on assertion:
  - state = IDLE; count = 0 (qd..qa = 0000); tc = 0; running = 0.
  - Prescaler, synchronizers and edge-detect history are all cleared.
  - Assertion mid-count aborts the count with no tc.
- Button input path:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~prev).
  - A button rising before clk edge k produces a one-cycle pulse that is acted on at edge k+2.
  - Holding a button produces exactly one pulse.
- State machine (updates only on edge-detect pulses):
  - IDLE + start -> RUN.
  - RUN + stop -> PAUSE.
  - PAUSE + start -> RUN. Count and prescaler phase are both kept.
  - PAUSE + stop -> IDLE, with count cleared to 0 at the same edge.
  - Start and stop pulses in the same cycle: stop wins.
  - All other combinations hold the current state.
  - running = (state == RUN), registered.
- Prescaler:
  - Counts 0..DIV-1 only in RUN and holds its value in PAUSE.
  - tick is high when the prescaler equals DIV-1 in RUN; the prescaler then returns to 0.
  - In IDLE the prescaler is held at 0.
  - Entering RUN from IDLE, the first count change occurs DIV cycles after running rises.
- Count update priority per edge (highest first):
  1. Reset.
  2. IDLE-clear (PAUSE + stop).
  3. load.
  4. tick.
- Load:
  - count <= load_val if load_val < MOD, else count <= MOD-1.
  - Accepted in every state.
  - A load coinciding with a tick suppresses that tick's increment and its tc; the prescaler still wraps.
- Tick:
  - dir=1: count+1, with MOD-1 wrapping to 0.
  - dir=0: count-1, with 0 wrapping to MOD-1.
- tc:
  - Registered, high for exactly the one cycle following the edge at which a wrap occurs.
  - Loads and clears never raise tc.
- qd..qa are driven directly from the count register: no glitches, and never a value ≥ MOD.

Test Plan (DIV=4, MOD=10):
- Reset mid-run:
  - Stimulus: run to count 5, then pulse rst asynchronously between clock edges.
  - Response: qd..qa = 0000, running = 0, and tc stays 0 throughout.
- Up count and wrap:
  - Stimulus: press start with dir=1.
  - Response: running rises 2 edges after sampling. The count goes 1, 2, … 9, 0, advancing every 4 cycles. tc pulses exactly once, the cycle after 9 -> 0.
- Down count and wrap:
  - Stimulus: dir=0 from count 0.
  - Response: next tick gives 9 (1001) and tc=1 for one cycle.
- Pause, resume, clear:
  - Stimulus: stop at count 3, wait 20 cycles, start.
  - Response: count stays 3 while paused and resumes to 4 within 4 cycles.
  - Stimulus: then stop twice.
  - Response: state IDLE, count 0.
- Load behaviour:
  - Stimulus: load_val = 7 in IDLE.
  - Response: count 7.
  - Stimulus: load_val = 12.
  - Response: count 9.
  - Stimulus: load coinciding with a tick.
  - Response: count = load_val, no tc.
- Button edge cases:
  - Stimulus: start and stop rising in the same cycle while RUN.
  - Response: PAUSE.
  - Stimulus: hold start high for 50 cycles.
  - Response: a single transition only.

Source files
------------

// File: rtl/seq_counter_ctrl.sv
// seq_counter_ctrl: button-driven run/pause/clear FSM gating a prescaled modulo-MOD up/down counter
// with synchronous load and a registered terminal-count pulse; feeds the 7-segment decoder.
module seq_counter_ctrl #(
    parameter int DIV = 4,
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       qd,
    output logic       qc,
    output logic       qb,
    output logic       qa,
    output logic       tc,
    output logic       running
);
    localparam int PW = $clog2(DIV);
    localparam logic [3:0] MAX = 4'(MOD - 1);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t state, nxt;
    logic [1:0] start_sync, stop_sync;
    logic start_prev, stop_prev, start_p, stop_p, tick, clear, wrap;
    logic [PW-1:0] pre;
    logic [3:0] cnt, cnt_nxt;
    assign start_p = start_sync[1] & ~start_prev;
    assign stop_p  = stop_sync[1] & ~stop_prev;
    assign clear   = state == PAUSE && stop_p;
    assign tick    = state == RUN && pre == PW'(DIV - 1);
    assign wrap    = dir ? cnt == MAX : cnt == 4'd0;
    assign {qd, qc, qb, qa} = cnt;
    // stop outranks start when both pulse together
    always_comb begin
        nxt = stop_p ? (state == RUN ? PAUSE : state == PAUSE ? IDLE : state)
            : (start_p && state != RUN) ? RUN : state;
        cnt_nxt = clear ? 4'd0
                : load ? (load_val > MAX ? MAX : load_val)
                : tick ? (dir ? (wrap ? 4'd0 : cnt + 4'd1) : (wrap ? MAX : cnt - 4'd1))
                : cnt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sync <= '0;
            stop_sync  <= '0;
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
            state      <= IDLE;
            running    <= 1'b0;
            pre        <= '0;
            cnt        <= 4'd0;
            tc         <= 1'b0;
        end else begin
            start_sync <= {start_sync[0], start_btn};
            stop_sync  <= {stop_sync[0], stop_btn};
            start_prev <= start_sync[1];
            stop_prev  <= stop_sync[1];
            state      <= nxt;
            running    <= nxt == RUN;
            pre        <= state == RUN ? (tick ? '0 : pre + 1'b1) : state == IDLE ? '0 : pre;
            cnt        <= cnt_nxt;
            tc         <= tick && !load && !clear && wrap;
        end
    end
endmodule
